ycbcr422_to_rgb565: RTL and testbench

- Inverse of the camera-side colour converter.
- Accepts the 4-slot signed YCbCr 4:2:2 byte stream: Y0, Cb, Cr, Y1, each byte tagged with a 2-bit slot number.
- Emits two RGB565 pixels per group.
- Sits on the decoder/display side after the MJPEG reconstruction path and feeds the LCD/frame-buffer writer.

---
 rtl/ycc_pkg.sv | 49 ++++
 rtl/ycc_pix_calc.sv | 138 +++++++++++++
 rtl/ycbcr422_to_rgb565.sv | 129 ++++++++++++
 tb/tb_ycbcr422_to_rgb565.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycc_pkg.sv
// ----------------------------------------------------------------------------
// ycc_pkg
// Shared definitions for the YCbCr 4:2:2 -> RGB565 display-side converter.
//   slot_t          : 2-bit slot tag carried alongside every stream byte
//   DEF_K_*         : default Q8 chroma coefficients (value / 256)
//   Y_OFS           : offset that turns the signed Y byte back into 0..255
//   PROD_W / SUM_W  : product and pre-saturation sum widths
//   sat_u8          : clamp a signed sum into 0..255
//   pack565         : pack three 8-bit channels into {R[7:3],G[7:2],B[7:3]}
// ----------------------------------------------------------------------------
package ycc_pkg;

  typedef enum logic [1:0] {
    SLOT_Y0 = 2'd0,
    SLOT_CB = 2'd1,
    SLOT_CR = 2'd2,
    SLOT_Y1 = 2'd3
  } slot_t;

  localparam int DEF_K_CR_R = 359;  // 1.402
  localparam int DEF_K_CB_G = 88;   // 0.344
  localparam int DEF_K_CR_G = 183;  // 0.714
  localparam int DEF_K_CB_B = 454;  // 1.772

  localparam int Y_OFS = 128;

  localparam int PROD_W = 18;
  localparam int SUM_W  = 11;

  // A negative sum clamps to 0; any set bit above bit 7 of a non-negative
  // sum means it exceeded 255 and clamps to full scale.
  function automatic logic [7:0] sat_u8(input logic [SUM_W-1:0] v);
    logic [7:0] res;
    if (v[SUM_W-1])
      res = 8'd0;
    else if (|v[SUM_W-2:8])
      res = 8'hFF;
    else
      res = v[7:0];
    return res;
  endfunction

  function automatic logic [15:0] pack565(input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/ycc_pix_calc.sv
// ----------------------------------------------------------------------------
// ycc_pix_calc
// Three-stage arithmetic for one pixel: signed Y/Cb/Cr bytes in, RGB565 out.
// Knows nothing about slot ordering; one launch per cycle at most.
//   clk, rst_n      : clock, asynchronous active-low reset
//   launch          : y_byte/cb_byte/cr_byte hold a pixel to convert
//   odd             : pixel index travelling with the launch (0=Y0, 1=Y1)
//   y_byte          : signed Y-128
//   cb_byte/cr_byte : signed centred chroma
//   rgb_data        : packed pixel, holds when rgb_valid is low
//   rgb_valid       : one-cycle pulse per finished pixel
//   pix_odd         : pixel index, valid with rgb_valid
// ----------------------------------------------------------------------------
module ycc_pix_calc
  import ycc_pkg::*;
#(
  parameter int K_CR_R = DEF_K_CR_R,
  parameter int K_CB_G = DEF_K_CB_G,
  parameter int K_CR_G = DEF_K_CR_G,
  parameter int K_CB_B = DEF_K_CB_B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        launch,
  input  logic        odd,
  input  logic [7:0]  y_byte,
  input  logic [7:0]  cb_byte,
  input  logic [7:0]  cr_byte,
  output logic [15:0] rgb_data,
  output logic        rgb_valid,
  output logic        pix_odd
);

  localparam logic signed [PROD_W-1:0] COEF_CR_R = PROD_W'(K_CR_R);
  localparam logic signed [PROD_W-1:0] COEF_CB_G = PROD_W'(K_CB_G);
  localparam logic signed [PROD_W-1:0] COEF_CR_G = PROD_W'(K_CR_G);
  localparam logic signed [PROD_W-1:0] COEF_CB_B = PROD_W'(K_CB_B);

  logic signed [PROD_W-1:0] cb_ext;
  logic signed [PROD_W-1:0] cr_ext;

  assign cb_ext = $signed({{(PROD_W-8){cb_byte[7]}}, cb_byte});
  assign cr_ext = $signed({{(PROD_W-8){cr_byte[7]}}, cr_byte});

  logic                     s1_valid;
  logic                     s1_odd;
  logic signed [9:0]        s1_y;
  logic signed [PROD_W-1:0] s1_p_r;
  logic signed [PROD_W-1:0] s1_p_cb_g;
  logic signed [PROD_W-1:0] s1_p_cr_g;
  logic signed [PROD_W-1:0] s1_p_b;

  // S1: restore the unsigned luma and form the four chroma products. The
  // data registers load every cycle; only the valid bit marks a real pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_odd    <= 1'b0;
      s1_y      <= '0;
      s1_p_r    <= '0;
      s1_p_cb_g <= '0;
      s1_p_cr_g <= '0;
      s1_p_b    <= '0;
    end else begin
      s1_valid  <= launch;
      s1_odd    <= odd;
      s1_y      <= $signed({{2{y_byte[7]}}, y_byte}) + 10'(Y_OFS);
      s1_p_r    <= COEF_CR_R * cr_ext;
      s1_p_cb_g <= COEF_CB_G * cb_ext;
      s1_p_cr_g <= COEF_CR_G * cr_ext;
      s1_p_b    <= COEF_CB_B * cb_ext;
    end
  end

  logic signed [PROD_W-1:0] p_g;
  logic signed [SUM_W-1:0]  y_w;
  logic signed [SUM_W-1:0]  r_off;
  logic signed [SUM_W-1:0]  g_off;
  logic signed [SUM_W-1:0]  b_off;
  logic signed [SUM_W-1:0]  r_sum;
  logic signed [SUM_W-1:0]  g_sum;
  logic signed [SUM_W-1:0]  b_sum;

  // S2 arithmetic: arithmetic shifts floor toward minus infinity. Every
  // shifted product fits comfortably in SUM_W bits, so the casts only drop
  // redundant sign bits, and Y +/- offset cannot overflow SUM_W.
  always_comb begin
    p_g   = s1_p_cb_g + s1_p_cr_g;
    y_w   = $signed({{(SUM_W-10){s1_y[9]}}, s1_y});
    r_off = SUM_W'(s1_p_r >>> 8);
    g_off = SUM_W'(p_g >>> 8);
    b_off = SUM_W'(s1_p_b >>> 8);
    r_sum = y_w + r_off;
    g_sum = y_w - g_off;
    b_sum = y_w + b_off;
  end

  logic       s2_valid;
  logic       s2_odd;
  logic [7:0] s2_r;
  logic [7:0] s2_g;
  logic [7:0] s2_b;

  // S2: clamp each channel into 0..255 so out-of-gamut colours saturate
  // instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_odd   <= 1'b0;
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_odd   <= s1_odd;
      s2_r     <= sat_u8(r_sum);
      s2_g     <= sat_u8(g_sum);
      s2_b     <= sat_u8(b_sum);
    end
  end

  // S3: pack to RGB565. Data and pixel index only move on a real pixel so
  // the output holds its last value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_data  <= '0;
      rgb_valid <= 1'b0;
      pix_odd   <= 1'b0;
    end else begin
      rgb_valid <= s2_valid;
      if (s2_valid) begin
        rgb_data <= pack565(s2_r, s2_g, s2_b);
        pix_odd  <= s2_odd;
      end
    end
  end

endmodule

// File: rtl/ycbcr422_to_rgb565.sv
// ----------------------------------------------------------------------------
// ycbcr422_to_rgb565
// Display-side converter: takes the slot-tagged signed YCbCr 4:2:2 byte
// stream (Y0, Cb, Cr, Y1) and emits two RGB565 pixels per group.
//   sys_clk    : clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   img_in     : signed stream byte (Y-128 or centred chroma)
//   state_in   : slot tag 0=Y0 1=Cb 2=Cr 3=Y1
//   in_en      : byte/tag valid this cycle
//   rgb_data   : {R[7:3],G[7:2],B[7:3]}, holds between pixels
//   rgb_valid  : one-cycle pulse per pixel
//   pix_odd    : 0 = pixel from Y0, 1 = pixel from Y1
//   sync_err   : one-cycle pulse when a byte arrives in the wrong slot
// ----------------------------------------------------------------------------
module ycbcr422_to_rgb565
  import ycc_pkg::*;
#(
  parameter int K_CR_R = DEF_K_CR_R,
  parameter int K_CB_G = DEF_K_CB_G,
  parameter int K_CR_G = DEF_K_CR_G,
  parameter int K_CB_B = DEF_K_CB_B
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  img_in,
  input  logic [1:0]  state_in,
  input  logic        in_en,
  output logic [15:0] rgb_data,
  output logic        rgb_valid,
  output logic        pix_odd,
  output logic        sync_err
);

  slot_t      expected;
  slot_t      slot;
  logic [7:0] y0_q;
  logic [7:0] cb_q;
  logic [7:0] cr_q;

  logic       launch_valid;
  logic       launch_odd;
  logic [7:0] launch_y;
  logic [7:0] launch_cb;
  logic [7:0] launch_cr;

  assign slot = slot_t'(state_in);

  // Slot tracker, capture registers and launch mux. Pixel 0 launches on the
  // Cr byte using that byte directly so it need not wait for the capture
  // register; pixel 1 launches on Y1 with the stored chroma. A stray Y0 tag
  // restarts the group from that byte; any other stray tag drops the byte
  // and waits for the next Y0. With in_en low everything holds.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      expected     <= SLOT_Y0;
      y0_q         <= '0;
      cb_q         <= '0;
      cr_q         <= '0;
      launch_valid <= 1'b0;
      launch_odd   <= 1'b0;
      launch_y     <= '0;
      launch_cb    <= '0;
      launch_cr    <= '0;
      sync_err     <= 1'b0;
    end else begin
      launch_valid <= 1'b0;
      sync_err     <= 1'b0;
      if (in_en) begin
        if (slot == expected) begin
          case (expected)
            SLOT_Y0: begin
              y0_q     <= img_in;
              expected <= SLOT_CB;
            end
            SLOT_CB: begin
              cb_q     <= img_in;
              expected <= SLOT_CR;
            end
            SLOT_CR: begin
              cr_q         <= img_in;
              launch_valid <= 1'b1;
              launch_odd   <= 1'b0;
              launch_y     <= y0_q;
              launch_cb    <= cb_q;
              launch_cr    <= img_in;
              expected     <= SLOT_Y1;
            end
            SLOT_Y1: begin
              launch_valid <= 1'b1;
              launch_odd   <= 1'b1;
              launch_y     <= img_in;
              launch_cb    <= cb_q;
              launch_cr    <= cr_q;
              expected     <= SLOT_Y0;
            end
            default: expected <= SLOT_Y0;
          endcase
        end else begin
          sync_err <= 1'b1;
          if (slot == SLOT_Y0) begin
            y0_q     <= img_in;
            expected <= SLOT_CB;
          end else begin
            expected <= SLOT_Y0;
          end
        end
      end
    end
  end

  ycc_pix_calc #(
    .K_CR_R (K_CR_R),
    .K_CB_G (K_CB_G),
    .K_CR_G (K_CR_G),
    .K_CB_B (K_CB_B)
  ) u_pix_calc (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .launch    (launch_valid),
    .odd       (launch_odd),
    .y_byte    (launch_y),
    .cb_byte   (launch_cb),
    .cr_byte   (launch_cr),
    .rgb_data  (rgb_data),
    .rgb_valid (rgb_valid),
    .pix_odd   (pix_odd)
  );

endmodule

// File: tb/tb_ycbcr422_to_rgb565.sv
// ----------------------------------------------------------------------------
// tb_ycbcr422_to_rgb565
// Directed scenarios followed by a randomized stream, all checked against a
// behavioural model of the slot rules and colour equations.
// ----------------------------------------------------------------------------
module tb_ycbcr422_to_rgb565;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  img_in;
  logic [1:0]  state_in;
  logic        in_en;
  logic [15:0] rgb_data;
  logic        rgb_valid;
  logic        pix_odd;
  logic        sync_err;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    logic [15:0] data;
    logic        odd;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] seen[$];
  int          seen_cyc[$];

  // Model of the slot tracker as described for the stream format.
  int          m_expected = 0;
  logic [7:0]  m_y0 = '0;
  logic [7:0]  m_cb = '0;
  logic [7:0]  m_cr = '0;

  ycbcr422_to_rgb565 dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .img_in    (img_in),
    .state_in  (state_in),
    .in_en     (in_en),
    .rgb_data  (rgb_data),
    .rgb_valid (rgb_valid),
    .pix_odd   (pix_odd),
    .sync_err  (sync_err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 sys_clk = ~sys_clk;

  // Count rising edges so pixel arrival can be checked to the cycle.
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic int floorDiv256(input int a);
    if (a >= 0)
      return a / 256;
    else
      return -((-a + 255) / 256);
  endfunction

  function automatic int clamp255(input int v);
    if (v < 0)
      return 0;
    else if (v > 255)
      return 255;
    else
      return v;
  endfunction

  // Reference colour conversion written straight from the equations.
  function automatic logic [15:0] refPixel(input logic [7:0] yb,
                                           input logic [7:0] cbb,
                                           input logic [7:0] crb);
    int y, cb, cr, r, g, b;
    y  = int'($signed(yb)) + 128;
    cb = int'($signed(cbb));
    cr = int'($signed(crb));
    r  = clamp255(y + floorDiv256(359 * cr));
    g  = clamp255(y - floorDiv256(88 * cb + 183 * cr));
    b  = clamp255(y + floorDiv256(454 * cb));
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkSeen(input string tag, input int idx,
                           input logic [15:0] exp);
    if (idx < seen.size())
      checkOutput(tag, {16'h0, seen[idx]}, {16'h0, exp});
  endtask

  // Apply the slot rules to one accepted byte; returns whether a slot error
  // is due and queues any pixel that byte completes.
  task automatic modelByte(input logic [7:0] d, input logic [1:0] s,
                           output logic err);
    err = 1'b0;
    if (int'(s) == m_expected) begin
      case (s)
        2'd0: begin m_y0 = d; m_expected = 1; end
        2'd1: begin m_cb = d; m_expected = 2; end
        2'd2: begin
          m_cr = d;
          exp_q.push_back('{refPixel(m_y0, m_cb, d), 1'b0, cyc + 3});
          m_expected = 3;
        end
        default: begin
          exp_q.push_back('{refPixel(d, m_cb, m_cr), 1'b1, cyc + 3});
          m_expected = 0;
        end
      endcase
    end else begin
      err = 1'b1;
      if (s == 2'd0) begin
        m_y0 = d;
        m_expected = 1;
      end else begin
        m_expected = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] s);
    logic exp_err;
    img_in   = d;
    state_in = s;
    in_en    = 1'b1;
    @(posedge sys_clk);
    #1;
    modelByte(d, s, exp_err);
    checkOutput("sync_err", {31'h0, sync_err}, {31'h0, exp_err});
    in_en  = 1'b0;
    img_in = 8'($urandom);
  endtask

  task automatic idleCycles(input int n);
    in_en = 1'b0;
    repeat (n) begin
      img_in   = 8'($urandom);
      state_in = 2'($urandom);
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic sendGroup(input logic [7:0] y0, input logic [7:0] cb,
                           input logic [7:0] cr, input logic [7:0] y1);
    applyStimulus(y0, 2'd0);
    applyStimulus(cb, 2'd1);
    applyStimulus(cr, 2'd2);
    applyStimulus(y1, 2'd3);
  endtask

  // Pixel monitor: every rgb_valid pulse must match the oldest queued pixel
  // in data, index and arrival cycle.
  always @(negedge sys_clk) begin
    exp_t e;
    if (rgb_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_valid", {31'h0, rgb_valid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pix_data", {16'h0, rgb_data}, {16'h0, e.data});
        checkOutput("pix_odd", {31'h0, pix_odd}, {31'h0, e.odd});
        checkOutput("pix_cycle", cyc, e.due);
      end
      seen.push_back(rgb_data);
      seen_cyc.push_back(cyc);
    end
  end

  // Hard time limit so a stuck run still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int t0;

    sys_rst_n = 1'b1;
    in_en     = 1'b0;
    img_in    = '0;
    state_in  = '0;
    #2 sys_rst_n = 1'b0;
    #2;
    checkOutput("rst_rgb_data", {16'h0, rgb_data}, 32'h0);
    checkOutput("rst_rgb_valid", {31'h0, rgb_valid}, 32'h0);
    checkOutput("rst_pix_odd", {31'h0, pix_odd}, 32'h0);
    checkOutput("rst_sync_err", {31'h0, sync_err}, 32'h0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] black and white");
    base = seen.size();
    sendGroup(8'h80, 8'h00, 8'h00, 8'h7F);
    idleCycles(4);
    checkOutput("bw_count", seen.size() - base, 2);
    checkSeen("bw_pix0", base, 16'h0000);
    checkSeen("bw_pix1", base + 1, 16'hFFFF);

    $display("[TB] pure red");
    base = seen.size();
    applyStimulus(8'hCC, 2'd0);
    t0 = cyc;
    applyStimulus(8'hD5, 2'd1);
    applyStimulus(8'h7F, 2'd2);
    applyStimulus(8'hCC, 2'd3);
    idleCycles(4);
    checkOutput("red_count", seen.size() - base, 2);
    checkSeen("red_pix0", base, 16'hF800);
    checkSeen("red_pix1", base + 1, 16'hF800);
    if (base < seen_cyc.size())
      checkOutput("red_latency", seen_cyc[base] - t0, 5);

    $display("[TB] saturation");
    base = seen.size();
    sendGroup(8'h7F, 8'h80, 8'h7F, 8'h7F);
    idleCycles(4);
    checkOutput("sat_count", seen.size() - base, 2);
    checkSeen("sat_pix0", base, 16'hFE83);
    checkSeen("sat_pix1", base + 1, 16'hFE83);

    $display("[TB] stall between Cb and Cr");
    base = seen.size();
    applyStimulus(8'hCC, 2'd0);
    t0 = cyc;
    applyStimulus(8'hD5, 2'd1);
    idleCycles(5);
    applyStimulus(8'h7F, 2'd2);
    applyStimulus(8'hCC, 2'd3);
    idleCycles(4);
    checkOutput("stall_count", seen.size() - base, 2);
    checkSeen("stall_pix0", base, 16'hF800);
    checkSeen("stall_pix1", base + 1, 16'hF800);
    if (base < seen_cyc.size())
      checkOutput("stall_latency", seen_cyc[base] - t0, 10);

    $display("[TB] sync error with skipped Cr");
    base = seen.size();
    applyStimulus(8'h11, 2'd0);
    applyStimulus(8'h22, 2'd1);
    applyStimulus(8'h33, 2'd3);
    idleCycles(4);
    checkOutput("skip_count", seen.size() - base, 0);
    sendGroup(8'h10, 8'h20, 8'hE0, 8'h90);
    idleCycles(4);
    checkOutput("recover_count", seen.size() - base, 2);

    $display("[TB] repeated Y0 resync");
    base = seen.size();
    applyStimulus(8'h05, 2'd0);
    applyStimulus(8'h30, 2'd0);
    applyStimulus(8'hF0, 2'd1);
    applyStimulus(8'h40, 2'd2);
    applyStimulus(8'hA0, 2'd3);
    idleCycles(4);
    checkOutput("resync_count", seen.size() - base, 2);
    checkSeen("resync_pix0", base, refPixel(8'h30, 8'hF0, 8'h40));

    $display("[TB] randomized stream");
    for (int g = 0; g < 30; g++) begin
      for (int s = 0; s < 4; s++) begin
        logic [1:0] sl;
        sl = 2'(s);
        if ($urandom_range(0, 9) == 0)
          sl = 2'($urandom_range(0, 3));
        applyStimulus(8'($urandom), sl);
        if ($urandom_range(0, 3) == 0)
          idleCycles(int'($urandom_range(1, 3)));
      end
    end
    idleCycles(5);

    $display("[TB] reset during flight");
    sendGroup(8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(8'hCC, 2'd0);
    applyStimulus(8'hD5, 2'd1);
    applyStimulus(8'h7F, 2'd2);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    exp_q.delete();
    m_expected = 0;
    m_y0 = '0;
    m_cb = '0;
    m_cr = '0;
    #1;
    checkOutput("midrst_rgb_data", {16'h0, rgb_data}, 32'h0);
    checkOutput("midrst_rgb_valid", {31'h0, rgb_valid}, 32'h0);
    checkOutput("midrst_pix_odd", {31'h0, pix_odd}, 32'h0);
    checkOutput("midrst_sync_err", {31'h0, sync_err}, 32'h0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    base = seen.size();
    idleCycles(6);
    applyStimulus(8'h55, 2'd1);
    applyStimulus(8'h66, 2'd2);
    idleCycles(5);
    checkOutput("post_rst_count", seen.size() - base, 0);
    sendGroup(8'h80, 8'h00, 8'h00, 8'h7F);

    idleCycles(8);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
